csr_slave_bridge: RTL and testbench
===================================

Name: csr_slave_bridge

Overview:
- Avalon-MM slave front end that feeds a bank of NUM_REGS 32-bit write-enabled registers; those registers clear on reset and hold their value when not written.
- Converts bus writes (with byte enables) into read-modify-write register updates: one shared data bus plus per-register write strobes.
- Muxes the register outputs back as bus reads.
- Adds a control/status pair that launches a downstream job and tracks busy/done.

Parameters:
- NUM_REGS, 4, number of external 32-bit registers driven; legal 1..14.
- ADDR_W, 4, word-address width; must satisfy 2^ADDR_W >= NUM_REGS+2.

Ports:
- clock  in  1  system clock; all state changes on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- address  in  ADDR_W  word address.
- write  in  1  Avalon write request.
- writedata  in  32  write data.
- byteenable  in  4  byte lanes; bit i enables writedata[8i+7:8i].
- read  in  1  Avalon read request.
- readdata  out  32  read data; valid only when readdatavalid=1.
- readdatavalid  out  1  one-cycle read-response strobe.
- waitrequest  out  1  slave stall.
- reg_d  out  32  shared data bus to the register bank.
- reg_write  out  NUM_REGS  one-hot write strobe per register.
- reg_q  in  32*NUM_REGS  register outputs; register k occupies [32k+31:32k].
- start  out  1  one-cycle job-launch pulse.
- done  in  1  job-complete pulse from the downstream engine.

Behaviour:
- Reset (async, reset_n=0) clears all state and outputs: readdata, readdatavalid, waitrequest, reg_d, reg_write, start, busy and done_sticky all go to 0, and the FSM returns to IDLE. A reset mid-commit or mid-job drops the operation; no strobe or pulse is emitted afterward.

Address map:
- 0..NUM_REGS-1: DATA[k], read/write.
- NUM_REGS: CTRL. Write with bit0=1 requests start; reads return 0.
- NUM_REGS+1: STATUS, bit0=busy, bit1=done_sticky. Writing 1 to bit1 clears done_sticky; other bits read 0.
- Any other address: writes are ignored (no strobe); reads return 0 with normal latency.

Bus FSM (states IDLE, COMMIT):
- IDLE: waitrequest=0.
- Write accepted at edge E (write=1, waitrequest=0) to DATA[k]:
  - reg_d is registered as the per-lane merge: writedata byte where byteenable=1, else reg_q[k] byte.
  - reg_write[k] is high for exactly the one cycle after E.
  - FSM enters COMMIT; the register loads at the next edge.
- COMMIT: waitrequest=1 for one cycle, then back to IDLE. A new transaction is accepted no earlier than 2 cycles after the previous write, so read-modify-write on the same register always sees updated data.
- Writes to CTRL, STATUS or unmapped addresses take effect at the accept edge and do not enter COMMIT.
- byteenable=0000 to DATA[k] still pulses reg_write[k], with reg_d equal to the old value (no change).

Reads:
- Accepted in IDLE when read=1 and write=0.
- readdata is registered and readdatavalid=1 in the cycle after acceptance. Fixed latency 1; back-to-back reads give one response per cycle.
- read and write asserted together: write wins; the read is not accepted and waitrequest=1 that cycle.

Job control:
- CTRL write with bit0=1 while busy=0: start=1 for the next cycle, busy set.
- CTRL write with bit0=1 while busy=1: ignored; no start pulse.
- done=1 while busy=1: busy clears and done_sticky sets on that edge. done while idle is ignored.
- done and a STATUS clear write on the same edge: set wins.
- A STATUS read returns the values before that edge's update.

Widths:
- reg_write and reg_d change only on clock edges; no combinational paths from bus inputs to bank outputs.

Test Plan:
- Reset sequence: hold reset_n=0 for 3 cycles, then release -> all outputs 0; reading STATUS returns 0x0.
- Full write: write DATA[2]=0xDEADBEEF, be=1111 -> one cycle later reg_d=0xDEADBEEF with reg_write=0100 for one cycle; waitrequest=1 for that cycle; a subsequent read of address 2 returns 0xDEADBEEF one cycle after acceptance.
- Byte merge: with DATA[1]=0x11223344, write 0xAABBCCDD with be=0101 -> reg_d=0x11BB33DD; the back-to-back write held by waitrequest merges against the updated value.
- Job handshake: write CTRL=1 -> start pulses once and STATUS=0x1. A second CTRL=1 produces no pulse. done pulse -> STATUS=0x2. Write STATUS=0x2 -> STATUS=0x0.
- Boundaries:
  - read and write together -> only the write is serviced.
  - Write to address 15 -> no reg_write; reading it returns 0 with readdatavalid.
  - done on the same edge as the clear write -> done_sticky=1.
- Reset mid-operation: assert reset_n=0 during COMMIT and while busy -> reg_write, start and busy drop immediately; no strobe or pulse after release.

Source files
------------

// File: rtl/csr_slave_bridge.sv
// Avalon-MM slave front end for a bank of external 32-bit registers, with a
// control/status pair that launches a downstream job and tracks busy/done.
module csr_slave_bridge #(
    parameter int NUM_REGS = 4,
    parameter int ADDR_W   = 4
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic [ADDR_W-1:0]       address,
    input  logic                    write,
    input  logic [31:0]             writedata,
    input  logic [3:0]              byteenable,
    input  logic                    read,
    output logic [31:0]             readdata,
    output logic                    readdatavalid,
    output logic                    waitrequest,
    output logic [31:0]             reg_d,
    output logic [NUM_REGS-1:0]     reg_write,
    input  logic [32*NUM_REGS-1:0]  reg_q,
    output logic                    start,
    input  logic                    done
);

    typedef enum logic {
        S_IDLE,
        S_COMMIT
    } state_t;

    localparam logic [ADDR_W-1:0] CTRL_ADDR   = ADDR_W'(NUM_REGS);
    localparam logic [ADDR_W-1:0] STATUS_ADDR = ADDR_W'(NUM_REGS + 1);

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  w_wr_acc;
    logic                  w_rd_acc;
    logic                  w_waitrequest;

    logic [31:0]           r_readdata;
    logic                  r_readdatavalid;
    logic [31:0]           r_reg_d;
    logic [NUM_REGS-1:0]   r_reg_write;
    logic                  r_start;
    logic                  r_busy;
    logic                  r_done_sticky;

    logic                  w_is_data;
    logic                  w_is_ctrl;
    logic                  w_is_status;
    logic [NUM_REGS-1:0]   w_strobe;
    logic [31:0]           w_sel_q;
    logic [31:0]           w_merge;
    logic [31:0]           w_rd_mux;
    logic                  w_start_req;
    logic                  w_done_hit;

    assign w_is_data   = (address < CTRL_ADDR);
    assign w_is_ctrl   = (address == CTRL_ADDR);
    assign w_is_status = (address == STATUS_ADDR);

    // NOTE: every signal written in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_strobe = '0;
        w_sel_q  = '0;
        for (int k = 0; k < NUM_REGS; k++) begin
            if (address == ADDR_W'(k)) begin
                w_strobe[k] = 1'b1;
                w_sel_q     = reg_q[32*k +: 32];
            end
        end
    end

    // Lanes not enabled keep the register's current contents (read-modify-write).
    always_comb begin
        w_merge = '0;
        for (int b = 0; b < 4; b++) begin
            w_merge[8*b +: 8] = byteenable[b] ? writedata[8*b +: 8] : w_sel_q[8*b +: 8];
        end
    end

    always_comb begin
        w_rd_mux = '0;
        if (w_is_data) begin
            w_rd_mux = w_sel_q;
        end else if (w_is_status) begin
            w_rd_mux = {30'd0, r_done_sticky, r_busy};
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A write always wins over a simultaneous read; only the read is stalled.
    always_comb begin
        w_state_nxt   = r_state;
        w_wr_acc      = 1'b0;
        w_rd_acc      = 1'b0;
        w_waitrequest = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_wr_acc      = write;
                w_rd_acc      = read && !write;
                w_waitrequest = read && write;
                if (write && w_is_data) begin
                    w_state_nxt = S_COMMIT;
                end
            end
            S_COMMIT: begin
                w_waitrequest = 1'b1;
                w_state_nxt   = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign w_start_req = w_wr_acc && w_is_ctrl && writedata[0] && !r_busy;
    assign w_done_hit  = done && r_busy;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_readdata      <= '0;
            r_readdatavalid <= 1'b0;
            r_reg_d         <= '0;
            r_reg_write     <= '0;
            r_start         <= 1'b0;
            r_busy          <= 1'b0;
            r_done_sticky   <= 1'b0;
        end else begin
            r_reg_write     <= '0;
            r_start         <= 1'b0;
            r_readdatavalid <= w_rd_acc;

            if (w_wr_acc && w_is_data) begin
                r_reg_d     <= w_merge;
                r_reg_write <= w_strobe;
            end

            if (w_rd_acc) begin
                r_readdata <= w_rd_mux;
            end

            if (w_start_req) begin
                r_start <= 1'b1;
                r_busy  <= 1'b1;
            end else if (w_done_hit) begin
                r_busy <= 1'b0;
            end

            // Completion takes priority over a clear on the same edge.
            if (w_done_hit) begin
                r_done_sticky <= 1'b1;
            end else if (w_wr_acc && w_is_status && writedata[1]) begin
                r_done_sticky <= 1'b0;
            end
        end
    end

    assign readdata      = r_readdata;
    assign readdatavalid = r_readdatavalid;
    assign waitrequest   = w_waitrequest;
    assign reg_d         = r_reg_d;
    assign reg_write     = r_reg_write;
    assign start         = r_start;

endmodule

// File: tb/tb_csr_slave_bridge.sv
// Directed self-checking bench for csr_slave_bridge with a behavioural
// model of the external register bank.
module tb_csr_slave_bridge;

    localparam int NUM_REGS = 4;
    localparam int ADDR_W   = 4;

    logic                    clock;
    logic                    reset_n;
    logic [ADDR_W-1:0]       address;
    logic                    write;
    logic [31:0]             writedata;
    logic [3:0]              byteenable;
    logic                    read;
    logic [31:0]             readdata;
    logic                    readdatavalid;
    logic                    waitrequest;
    logic [31:0]             reg_d;
    logic [NUM_REGS-1:0]     reg_write;
    logic [32*NUM_REGS-1:0]  reg_q;
    logic                    start;
    logic                    done;

    logic [31:0]             bank [NUM_REGS];
    int                      n_cmp;
    int                      n_err;

    csr_slave_bridge #(
        .NUM_REGS (NUM_REGS),
        .ADDR_W   (ADDR_W)
    ) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .address       (address),
        .write         (write),
        .writedata     (writedata),
        .byteenable    (byteenable),
        .read          (read),
        .readdata      (readdata),
        .readdatavalid (readdatavalid),
        .waitrequest   (waitrequest),
        .reg_d         (reg_d),
        .reg_write     (reg_write),
        .reg_q         (reg_q),
        .start         (start),
        .done          (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // External register bank: clears on reset, loads reg_d on its strobe.
    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < NUM_REGS; k++) bank[k] <= '0;
        end else begin
            for (int k = 0; k < NUM_REGS; k++) begin
                if (reg_write[k]) bank[k] <= reg_d;
            end
        end
    end

    always_comb begin
        reg_q = '0;
        for (int k = 0; k < NUM_REGS; k++) reg_q[32*k +: 32] = bank[k];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (waitrequest === 1'b1 && n < 16) begin
            tick();
            n++;
        end
        if (n >= 16) check("wait_timeout", 32'd1, 32'd0);
    endtask

    // Returns 1 ns after the accepting edge.
    task automatic bus_write(input logic [ADDR_W-1:0] a, input logic [31:0] d, input logic [3:0] be);
        address    = a;
        writedata  = d;
        byteenable = be;
        write      = 1'b1;
        #1;
        wait_ready();
        tick();
        write = 1'b0;
    endtask

    task automatic bus_read(input logic [ADDR_W-1:0] a, output logic [31:0] d, output logic v);
        address = a;
        read    = 1'b1;
        #1;
        wait_ready();
        tick();
        read = 1'b0;
        d    = readdata;
        v    = readdatavalid;
    endtask

    task automatic pulse_done();
        done = 1'b1;
        tick();
        done = 1'b0;
    endtask

    initial begin
        logic [31:0] rd;
        logic        rv;
        logic        seen;

        n_cmp      = 0;
        n_err      = 0;
        address    = '0;
        write      = 1'b0;
        writedata  = '0;
        byteenable = '0;
        read       = 1'b0;
        done       = 1'b0;
        reset_n    = 1'b1;
        #1 reset_n = 1'b0;

        repeat (3) tick();
        check("rst_readdata",  readdata, 32'h0);
        check("rst_rdvalid",   {31'd0, readdatavalid}, 32'h0);
        check("rst_waitreq",   {31'd0, waitrequest}, 32'h0);
        check("rst_reg_d",     reg_d, 32'h0);
        check("rst_reg_write", {28'd0, reg_write}, 32'h0);
        check("rst_start",     {31'd0, start}, 32'h0);
        reset_n = 1'b1;
        tick();
        bus_read(4'd5, rd, rv);
        check("rst_status", rd, 32'h0);
        check("rst_status_v", {31'd0, rv}, 32'h1);

        // Full-word write and readback
        bus_write(4'd2, 32'hDEADBEEF, 4'b1111);
        check("full_reg_d", reg_d, 32'hDEADBEEF);
        check("full_strobe", {28'd0, reg_write}, 32'h4);
        check("full_wait", {31'd0, waitrequest}, 32'h1);
        tick();
        check("full_strobe_off", {28'd0, reg_write}, 32'h0);
        check("full_wait_off", {31'd0, waitrequest}, 32'h0);
        bus_read(4'd2, rd, rv);
        check("full_read", rd, 32'hDEADBEEF);
        check("full_read_v", {31'd0, rv}, 32'h1);

        // Byte-lane merges, issued back to back through waitrequest
        bus_write(4'd1, 32'h11223344, 4'b1111);
        bus_write(4'd1, 32'hAABBCCDD, 4'b0101);
        check("merge_0101", reg_d, 32'h11BB33DD);
        check("merge_strobe", {28'd0, reg_write}, 32'h2);
        bus_write(4'd1, 32'hFFFFFFFF, 4'b0000);
        check("merge_none", reg_d, 32'h11BB33DD);
        check("merge_none_strobe", {28'd0, reg_write}, 32'h2);
        bus_write(4'd1, 32'h5A000000, 4'b1000);
        check("merge_1000", reg_d, 32'h5ABB33DD);
        bus_read(4'd1, rd, rv);
        check("merge_read", rd, 32'h5ABB33DD);

        // Job handshake
        bus_write(4'd4, 32'h1, 4'b1111);
        check("job_start", {31'd0, start}, 32'h1);
        tick();
        check("job_start_off", {31'd0, start}, 32'h0);
        bus_read(4'd5, rd, rv);
        check("job_busy", rd, 32'h1);
        bus_write(4'd4, 32'h1, 4'b1111);
        check("job_restart_none", {31'd0, start}, 32'h0);
        tick();
        check("job_restart_none2", {31'd0, start}, 32'h0);
        pulse_done();
        bus_read(4'd5, rd, rv);
        check("job_done", rd, 32'h2);
        pulse_done();
        bus_read(4'd5, rd, rv);
        check("job_done_idle", rd, 32'h2);
        bus_write(4'd5, 32'h2, 4'b1111);
        bus_read(4'd5, rd, rv);
        check("job_clear", rd, 32'h0);
        bus_read(4'd4, rd, rv);
        check("ctrl_read", rd, 32'h0);

        // done on the same edge as a clear: the set wins
        bus_write(4'd4, 32'h1, 4'b1111);
        pulse_done();
        bus_write(4'd4, 32'h1, 4'b1111);
        check("job_start_again", {31'd0, start}, 32'h1);
        address    = 4'd5;
        writedata  = 32'h2;
        byteenable = 4'b1111;
        write      = 1'b1;
        done       = 1'b1;
        tick();
        write = 1'b0;
        done  = 1'b0;
        bus_read(4'd5, rd, rv);
        check("set_beats_clear", rd, 32'h2);

        // Read and write together: only the write is serviced
        address    = 4'd0;
        writedata  = 32'h12345678;
        byteenable = 4'b1111;
        write      = 1'b1;
        read       = 1'b1;
        #1;
        check("rw_wait", {31'd0, waitrequest}, 32'h1);
        tick();
        write = 1'b0;
        read  = 1'b0;
        check("rw_strobe", {28'd0, reg_write}, 32'h1);
        check("rw_no_rdv", {31'd0, readdatavalid}, 32'h0);
        tick();
        bus_read(4'd0, rd, rv);
        check("rw_read", rd, 32'h12345678);

        // Back-to-back reads, one response per cycle
        address = 4'd2;
        read    = 1'b1;
        tick();
        check("b2b_rd0", rd === 32'h0 ? readdata : readdata, 32'hDEADBEEF);
        check("b2b_v0", {31'd0, readdatavalid}, 32'h1);
        address = 4'd1;
        tick();
        check("b2b_rd1", readdata, 32'h5ABB33DD);
        check("b2b_v1", {31'd0, readdatavalid}, 32'h1);
        read = 1'b0;
        tick();
        check("b2b_v_off", {31'd0, readdatavalid}, 32'h0);

        // Unmapped address
        bus_write(4'd15, 32'hFFFFFFFF, 4'b1111);
        check("unmap_strobe", {28'd0, reg_write}, 32'h0);
        check("unmap_no_commit", {31'd0, waitrequest}, 32'h0);
        bus_read(4'd15, rd, rv);
        check("unmap_read", rd, 32'h0);
        check("unmap_read_v", {31'd0, rv}, 32'h1);

        // Reset during COMMIT while a job is busy
        pulse_done();
        bus_write(4'd4, 32'h1, 4'b1111);
        bus_write(4'd3, 32'hCAFEF00D, 4'b1111);
        check("mid_strobe", {28'd0, reg_write}, 32'h8);
        reset_n = 1'b0;
        #1;
        check("mid_rst_strobe", {28'd0, reg_write}, 32'h0);
        check("mid_rst_start", {31'd0, start}, 32'h0);
        check("mid_rst_wait", {31'd0, waitrequest}, 32'h0);
        check("mid_rst_reg_d", reg_d, 32'h0);
        tick();
        tick();
        reset_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (reg_write != '0 || start) seen = 1'b1;
        end
        check("post_rst_quiet", {31'd0, seen}, 32'h0);
        bus_read(4'd5, rd, rv);
        check("post_rst_status", rd, 32'h0);
        bus_read(4'd3, rd, rv);
        check("post_rst_data3", rd, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
